// File: rtl/debounce_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the multi-channel button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } debounce_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
`timescale 1ns/1ps
// One button channel: synchroniser, bounce filter FSM and optional long-press detector.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned BOUNCE_TICKS = 10,
  parameter int unsigned HOLD_TICKS   = 0,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic held
);

  localparam int unsigned CNT_W = $clog2(max_u(BOUNCE_TICKS, HOLD_TICKS) + 1);
  localparam logic [CNT_W-1:0] BOUNCE_MAX = CNT_W'(BOUNCE_TICKS);
  localparam logic [CNT_W-1:0] HOLD_MAX   = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] HOLD_LAST  = (HOLD_TICKS > 0) ? CNT_W'(HOLD_TICKS - 1) : '0;
  localparam bit               HOLD_EN    = (HOLD_TICKS > 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  debounce_state_t        state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       hold_q;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   held_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Filter FSM; the hold counter only runs while the accepted level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOW;
      cnt_q   <= '0;
      hold_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      held_q <= 1'b0;
      if (HOLD_EN && level_q && ena && (hold_q != HOLD_MAX)) begin
        hold_q <= hold_q + CNT_W'(1);
        held_q <= (hold_q == HOLD_LAST);
      end
      case (state_q)
        LOW: begin
          if (s) begin
            state_q <= WAIT_HIGH;
            cnt_q   <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            state_q <= LOW;
          end else if (ena) begin
            if (cnt_q == BOUNCE_MAX) begin
              state_q <= HIGH;
              level_q <= 1'b1;
              rise_q  <= 1'b1;
              hold_q  <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        HIGH: begin
          if (!s) begin
            state_q <= WAIT_LOW;
            cnt_q   <= '0;
          end
        end
        WAIT_LOW: begin
          if (s) begin
            state_q <= HIGH;
          end else if (ena) begin
            if (cnt_q == BOUNCE_MAX) begin
              state_q <= LOW;
              level_q <= 1'b0;
              fall_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= LOW;
      endcase
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign held  = held_q;

endmodule

// File: rtl/debounce_bank.sv
`timescale 1ns/1ps
// N independent debounce channels with concatenated level and event outputs.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned N            = 2,
  parameter int unsigned BOUNCE_TICKS = 10,
  parameter int unsigned HOLD_TICKS   = 0,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] raw,
  output logic [N-1:0] level,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] held
);

  for (genvar g = 0; g < N; g++) begin : g_ch
    debounce_channel #(
      .BOUNCE_TICKS(BOUNCE_TICKS),
      .HOLD_TICKS  (HOLD_TICKS),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .ena  (ena),
      .raw  (raw[g]),
      .level(level[g]),
      .rise (rise[g]),
      .fall (fall[g]),
      .held (held[g])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
`timescale 1ns/1ps
// Randomised bench for debounce_bank against a tick-counting reference model.
module tb_debounce_bank;

  localparam int N = 2;
  localparam int B = 10;
  localparam int H = 50;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic [N-1:0] raw;
  logic [N-1:0] level, rise, fall, held;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  debounce_bank #(
    .N(N), .BOUNCE_TICKS(B), .HOLD_TICKS(H), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .raw(raw),
    .level(level), .rise(rise), .fall(fall), .held(held)
  );

  // Reference: a level flips once the synchronised input has disagreed with it on
  // the entry edge plus B+1 further enabled edges; any agreeing sample restarts that.
  logic [N-1:0] m_level = '0, m_rise = '0, m_fall = '0, m_held = '0;
  logic [S-1:0] m_pipe [N];
  int           m_ticks [N];
  bit           m_wait [N];
  int           m_hold [N];
  bit           m_hdone [N];
  bit           m_s;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        m_pipe[i] = '0; m_level[i] = 1'b0; m_rise[i] = 1'b0; m_fall[i] = 1'b0;
        m_held[i] = 1'b0; m_ticks[i] = 0; m_wait[i] = 0; m_hold[i] = 0; m_hdone[i] = 0;
      end else begin
        m_s = m_pipe[i][S-1];
        m_pipe[i] = {m_pipe[i][S-2:0], raw[i]};
        m_rise[i] = 1'b0; m_fall[i] = 1'b0; m_held[i] = 1'b0;
        if (m_level[i] && ena && !m_hdone[i]) begin
          m_hold[i]++;
          if (m_hold[i] == H) begin m_held[i] = 1'b1; m_hdone[i] = 1; end
        end
        if (m_s == m_level[i]) m_wait[i] = 0;
        else if (!m_wait[i]) begin m_wait[i] = 1; m_ticks[i] = 0; end
        else if (ena) begin
          m_ticks[i]++;
          if (m_ticks[i] == B + 1) begin
            m_wait[i] = 0;
            if (m_level[i]) m_fall[i] = 1'b1;
            else begin m_rise[i] = 1'b1; m_hold[i] = 0; m_hdone[i] = 0; end
            m_level[i] = ~m_level[i];
          end
        end
      end
    end
  end

  task automatic bounce_ch1(input logic final_v);
    int n, d;
    n = $urandom_range(10, 29);
    repeat (n) begin
      d = $urandom_range(1, 15);
      #d;
      if ($time % 5 == 0) #1;
      raw[1] = ~raw[1];
    end
    #1;
    if ($time % 5 == 0) #1;
    raw[1] = final_v;
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1; ena = 1'b1; raw = 2'b11;
    repeat (2) begin
      @(negedge clk);
      tests++;
      if ({level, rise, fall, held} !== 8'h00) begin
        fails++; $display("FAIL reset_outputs: got %b want 00000000", {level, rise, fall, held});
      end
    end
    rst = 1'b0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      tests++;
      if ({level, rise, fall, held} !== {m_level, m_rise, m_fall, m_held}) begin
        fails++; $display("FAIL reset_model k=%0d: got %b want %b", k, {level, rise, fall, held}, {m_level, m_rise, m_fall, m_held});
      end
      if (lat < 0 && level == 2'b11) begin
        lat = k;
        tests++;
        if (rise !== 2'b11) begin fails++; $display("FAIL reset_rise_with_level: got %b want 11", rise); end
      end
    end
    tests++;
    if (lat != S + 1 + B) begin fails++; $display("FAIL reset_latency: got %0d want %0d", lat, S + 1 + B); end
  endtask

  task automatic test_glitch();
    int nr;
    raw = 2'b00;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      tests++;
      if ({level, rise, fall, held} !== {m_level, m_rise, m_fall, m_held}) begin
        fails++; $display("FAIL glitch_settle: got %b want %b", {level, rise, fall, held}, {m_level, m_rise, m_fall, m_held});
      end
    end
    nr = 0;
    raw[0] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 8) raw[0] = 1'b0;
      nr += int'(rise[0]);
      tests++;
      if ({level, rise, fall, held} !== {m_level, m_rise, m_fall, m_held}) begin
        fails++; $display("FAIL glitch_short: got %b want %b", {level, rise, fall, held}, {m_level, m_rise, m_fall, m_held});
      end
    end
    tests++;
    if (nr != 0 || level[0] !== 1'b0) begin fails++; $display("FAIL glitch_reject: rises %0d level %b want 0 0", nr, level[0]); end
    nr = 0;
    raw[0] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      nr += int'(rise[0]);
    end
    tests++;
    if (nr != 1 || level[0] !== 1'b1) begin fails++; $display("FAIL glitch_accept: rises %0d level %b want 1 1", nr, level[0]); end
    raw[0] = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_bounce();
    int nr, nf;
    for (int it = 0; it < 5; it++) begin
      for (int dir = 1; dir >= 0; dir--) begin
        nr = 0; nf = 0;
        fork
          bounce_ch1(1'(dir));
          for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            nr += int'(rise[1]); nf += int'(fall[1]);
            tests++;
            if ({level, rise, fall, held} !== {m_level, m_rise, m_fall, m_held}) begin
              fails++; $display("FAIL bounce_model it=%0d k=%0d: got %b want %b", it, k, {level, rise, fall, held}, {m_level, m_rise, m_fall, m_held});
            end
          end
        join
        tests++;
        if (nr != dir || nf != 1 - dir || level[1] !== 1'(dir)) begin
          fails++; $display("FAIL bounce_events it=%0d: rise %0d fall %0d level %b want %0d %0d %0d", it, nr, nf, level[1], dir, 1 - dir, dir);
        end
      end
    end
  endtask

  task automatic test_tick_enable();
    int lat;
    raw = 2'b00;
    lat = -1;
    raw[0] = 1'b1;
    for (int k = 0; k < 80; k++) begin
      ena = (k % 4 == 0);
      @(negedge clk);
      if (lat < 0 && level[0]) lat = k;
      tests++;
      if ({level, rise, fall, held} !== {m_level, m_rise, m_fall, m_held}) begin
        fails++; $display("FAIL tick_model k=%0d: got %b want %b", k, {level, rise, fall, held}, {m_level, m_rise, m_fall, m_held});
      end
    end
    tests++;
    if (lat < S + 1 + 4 * B || lat > S + 4 * (B + 1)) begin
      fails++; $display("FAIL tick_latency: got %0d want %0d..%0d", lat, S + 1 + 4 * B, S + 4 * (B + 1));
    end
    // Part-way through a wait, drop the input while ticks are frozen.
    ena = 1'b1; raw[1] = 1'b1;
    repeat (S + 1 + 6) @(negedge clk);
    ena = 1'b0; raw[1] = 1'b0;
    repeat (4) @(negedge clk);
    raw[1] = 1'b1; ena = 1'b1;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (lat < 0 && level[1]) lat = k;
      tests++;
      if ({level, rise, fall, held} !== {m_level, m_rise, m_fall, m_held}) begin
        fails++; $display("FAIL tick_abort_model k=%0d: got %b want %b", k, {level, rise, fall, held}, {m_level, m_rise, m_fall, m_held});
      end
    end
    tests++;
    if (lat != S + 1 + B) begin fails++; $display("FAIL tick_abort_restart: got %0d want %0d", lat, S + 1 + B); end
    raw = 2'b00;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_hold();
    int nr, nh, rc, hc;
    ena = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      nr = 0; nh = 0; rc = -1; hc = -1;
      raw[0] = 1'b1;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (rise[0]) begin nr++; rc = k; end
        if (held[0]) begin nh++; hc = k; end
        tests++;
        if ({level, rise, fall, held} !== {m_level, m_rise, m_fall, m_held}) begin
          fails++; $display("FAIL hold_model k=%0d: got %b want %b", k, {level, rise, fall, held}, {m_level, m_rise, m_fall, m_held});
        end
      end
      tests++;
      if (nr != 1 || nh != 1 || hc - rc != H) begin
        fails++; $display("FAIL hold_pass%0d: rise %0d held %0d gap %0d want 1 1 %0d", pass, nr, nh, hc - rc, H);
      end
      raw[0] = 1'b0;
      repeat (40) @(negedge clk);
    end
  endtask

  task automatic test_independence_and_reset();
    int nr0, ne1;
    raw = 2'b00; ena = 1'b1;
    nr0 = 0; ne1 = 0;
    fork
      begin raw[0] = 1'b1; bounce_ch1(1'b0); end
      for (int k = 0; k < 150; k++) begin
        @(negedge clk);
        nr0 += int'(rise[0]); ne1 += int'(rise[1]) + int'(fall[1]);
        tests++;
        if ({level, rise, fall, held} !== {m_level, m_rise, m_fall, m_held}) begin
          fails++; $display("FAIL indep_model k=%0d: got %b want %b", k, {level, rise, fall, held}, {m_level, m_rise, m_fall, m_held});
        end
      end
    join
    tests++;
    if (nr0 != 1 || ne1 != 0 || level !== 2'b01) begin
      fails++; $display("FAIL indep_events: rise0 %0d ch1 events %0d level %b want 1 0 01", nr0, ne1, level);
    end
    raw = 2'b00;
    repeat (40) @(negedge clk);
    raw = 2'b11;
    repeat (S + 1 + 4) @(negedge clk);
    rst = 1'b1; raw = 2'b00;
    @(negedge clk);
    tests++;
    if ({level, rise, fall, held} !== 8'h00) begin
      fails++; $display("FAIL midwait_reset: got %b want 00000000", {level, rise, fall, held});
    end
    rst = 1'b0;
    nr0 = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      nr0 += int'(rise[0]) + int'(rise[1]);
    end
    tests++;
    if (nr0 != 0 || level !== 2'b00) begin
      fails++; $display("FAIL midwait_no_rise: rises %0d level %b want 0 00", nr0, level);
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; raw = 2'b11;
    test_reset();
    test_glitch();
    test_bounce();
    test_tick_enable();
    test_hold();
    test_independence_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
